// File: rtl/load_store_unit.sv
// load_store_unit -- MIPS memory stage in front of a word-addressed data memory.
// Turns byte/half/word loads and stores into aligned word accesses. Sub-word
// stores are done as read-modify-write. Misaligned requests are rejected
// without touching memory. The pipeline is stalled until the access completes.
// Optional performance counters are enabled with the macro LSU_PERF_CNT_EN.
module load_store_unit #(
   parameter int ADDR_W        = 32,
   parameter int WORD_ADDR_BIT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_load,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              misalign,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
`ifdef LSU_PERF_CNT_EN
   ,
   output logic [15:0]       ld_cnt,
   output logic [15:0]       st_cnt,
   output logic [7:0]        misalign_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD,
      S_ST,
      S_RMW_RD,
      S_RMW_WR,
      S_RESP
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic              r_signed;
   logic              r_load;
   logic [31:0]       r_wdata;
   logic [31:0]       r_merge;
   logic [31:0]       r_rdata;
   logic              r_respValid;
   logic              r_misalign;

   logic              w_reqMisalign;
   logic [7:0]        w_ldByte;
   logic [15:0]       w_ldHalf;
   logic [31:0]       w_ldData;
   logic [31:0]       w_mergeData;
   logic              w_access;
   logic              w_memWr;
   logic [ADDR_W-1:0] w_wordAddr;

   // Alignment check on the live request; size 11 is never legal.
   always_comb begin
      w_reqMisalign = 1'b0;
      case (req_size)
         2'b00:   w_reqMisalign = 1'b0;
         2'b01:   w_reqMisalign = req_addr[0];
         2'b10:   w_reqMisalign = |req_addr[1:0];
         default: w_reqMisalign = 1'b1;
      endcase
   end

   // Pick the addressed lane(s) out of the memory word and extend to 32 bits.
   always_comb begin
      w_ldByte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
      w_ldHalf = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (r_size)
         2'b00:   w_ldData = r_signed ? {{24{w_ldByte[7]}}, w_ldByte} : {24'd0, w_ldByte};
         2'b01:   w_ldData = r_signed ? {{16{w_ldHalf[15]}}, w_ldHalf} : {16'd0, w_ldHalf};
         default: w_ldData = mem_rdata;
      endcase
   end

   // Overlay the store byte/half onto the word captured during the RMW read.
   always_comb begin
      w_mergeData = r_merge;
      if (r_size == 2'b00) begin
         w_mergeData[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      end else begin
         w_mergeData[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
   end

   // Memory-facing controls; reset suppresses any access, even mid-RMW.
   always_comb begin
      w_access   = (r_state == S_LD) || (r_state == S_ST) ||
                   (r_state == S_RMW_RD) || (r_state == S_RMW_WR);
      w_memWr    = ~reset & ((r_state == S_ST) || (r_state == S_RMW_WR));
      w_wordAddr = {r_addr[ADDR_W-1:WORD_ADDR_BIT+2], r_addr[WORD_ADDR_BIT+1:2], 2'b00};
      mem_rd     = ~reset & ((r_state == S_LD) || (r_state == S_RMW_RD));
      mem_wr     = w_memWr;
      mem_addr   = w_access ? w_wordAddr : '0;
      if (!w_memWr) begin
         mem_wdata = 32'd0;
      end else if (r_state == S_ST) begin
         mem_wdata = r_wdata;
      end else begin
         mem_wdata = w_mergeData;
      end
   end

   // The pipeline is held while a request waits in IDLE or an access is in flight.
   always_comb begin
      if (r_state == S_IDLE) begin
         stall = req_valid;
      end else begin
         stall = (r_state != S_RESP);
      end
   end

   assign resp_valid = r_respValid;
   assign misalign   = r_misalign;
   assign resp_rdata = r_rdata;

   // Main sequencer: latches the request in IDLE and walks it through the access states.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_size      <= 2'b00;
         r_signed    <= 1'b0;
         r_load      <= 1'b0;
         r_wdata     <= 32'd0;
         r_merge     <= 32'd0;
         r_rdata     <= 32'd0;
         r_respValid <= 1'b0;
         r_misalign  <= 1'b0;
      end else begin
         r_respValid <= 1'b0;
         r_misalign  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_addr   <= req_addr;
                  r_size   <= req_size;
                  r_signed <= req_signed;
                  r_load   <= req_load;
                  r_wdata  <= req_wdata;
                  if (w_reqMisalign) begin
                     r_state     <= S_RESP;
                     r_respValid <= 1'b1;
                     r_misalign  <= 1'b1;
                  end else if (req_load) begin
                     r_state <= S_LD;
                  end else if (req_size == 2'b10) begin
                     r_state <= S_ST;
                  end else begin
                     r_state <= S_RMW_RD;
                  end
               end
            end
            S_LD: begin
               r_rdata     <= w_ldData;
               r_respValid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_ST: begin
               r_respValid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RMW_RD: begin
               r_merge <= mem_rdata;
               r_state <= S_RMW_WR;
            end
            S_RMW_WR: begin
               r_respValid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               r_rdata <= 32'd0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef LSU_PERF_CNT_EN
   logic [15:0] r_ldCnt;
   logic [15:0] r_stCnt;
   logic [7:0]  r_misalignCnt;

   // Count completed accesses in their RESP cycle; a rejected access only bumps the misalign count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ldCnt       <= 16'd0;
         r_stCnt       <= 16'd0;
         r_misalignCnt <= 8'd0;
      end else if (r_state == S_RESP) begin
         if (r_misalign) begin
            r_misalignCnt <= r_misalignCnt + 8'd1;
         end else if (r_load) begin
            r_ldCnt <= r_ldCnt + 16'd1;
         end else begin
            r_stCnt <= r_stCnt + 16'd1;
         end
      end
   end

   assign ld_cnt       = r_ldCnt;
   assign st_cnt       = r_stCnt;
   assign misalign_cnt = r_misalignCnt;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: a behavioural word memory hangs off the memory
// port, a reference memory image predicts every load result and every written word,
// and expected responses are queued when a request is driven and checked on resp_valid.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_load;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        misalign;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
`ifdef LSU_PERF_CNT_EN
   logic [15:0] ld_cnt;
   logic [15:0] st_cnt;
   logic [7:0]  misalign_cnt;
`endif

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      int          lat;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] mem    [0:255];
   logic [31:0] refMem [0:255];
   int          checks = 0;
   int          errors = 0;
   int          nLd = 0;
   int          nSt = 0;
   int          nMis = 0;

   load_store_unit #(.ADDR_W(32), .WORD_ADDR_BIT(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_load   (req_load),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .misalign   (misalign),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
`ifdef LSU_PERF_CNT_EN
      ,
      .ld_cnt       (ld_cnt),
      .st_cnt       (st_cnt),
      .misalign_cnt (misalign_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Word memory: combinational read, write committed on the falling edge.
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(negedge clk) begin
      if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      if (sz == 2'b00) return sg ? {{24{b[7]}}, b} : {24'd0, b};
      if (sz == 2'b01) return sg ? {{16{h[15]}}, h} : {16'd0, h};
      return w;
   endfunction

   function automatic logic [31:0] modelStore(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] off, input logic [31:0] d);
      logic [31:0] r;
      r = w;
      if (sz == 2'b10) begin
         r = d;
      end else if (sz == 2'b01) begin
         if (off[1]) r[31:16] = d[15:0];
         else        r[15:0]  = d[15:0];
      end else begin
         case (off)
            2'd0:    r[7:0]   = d[7:0];
            2'd1:    r[15:8]  = d[7:0];
            2'd2:    r[23:16] = d[7:0];
            default: r[31:24] = d[7:0];
         endcase
      end
      return r;
   endfunction

   // Drives one request (called just after a rising edge) and follows it to its response.
   task automatic applyStimulus(input logic ld, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd);
      exp_t        e;
      exp_t        got;
      logic        mis;
      logic [7:0]  idx;
      logic [31:0] newW;
      logic [31:0] wrAddr;
      logic [31:0] wrData;
      int          wrCnt;
      int          rdCnt;
      int          stallBad;
      bit          done;
      idx  = a[9:2];
      mis  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      newW = 32'd0;
      e.mis   = mis;
      e.rdata = 32'd0;
      if (mis) begin
         e.lat = 2;
         nMis++;
      end else if (ld) begin
         e.lat   = 3;
         e.rdata = modelLoad(refMem[idx], sz, sg, a[1:0]);
         nLd++;
      end else begin
         e.lat       = (sz == 2'b10) ? 3 : 4;
         newW        = modelStore(refMem[idx], sz, a[1:0], wd);
         refMem[idx] = newW;
         nSt++;
      end
      expQ.push_back(e);
      req_valid  = 1'b1;
      req_load   = ld;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      wrCnt = 0; rdCnt = 0; stallBad = 0; done = 0;
      wrAddr = 32'd0; wrData = 32'd0;
      for (int n = 1; n <= 8 && !done; n++) begin
         @(negedge clk);
         if (mem_wr) begin
            wrCnt++;
            wrAddr = mem_addr;
            wrData = mem_wdata;
         end
         if (mem_rd) begin
            rdCnt++;
            checkOutput("rd_addr", mem_addr, {a[31:2], 2'b00});
         end
         if (resp_valid) begin
            done = 1;
            if (expQ.size() == 0) begin
               checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
               got = expQ.pop_front();
               checkOutput("latency", n, got.lat);
               checkOutput("resp_rdata", resp_rdata, got.rdata);
               checkOutput("misalign", {31'd0, misalign}, {31'd0, got.mis});
               checkOutput("stall_in_resp", {31'd0, stall}, 32'd0);
            end
         end else if (!stall) begin
            stallBad++;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checkOutput("resp_timeout", 32'd0, 32'd1);
         expQ.delete();
      end
      checkOutput("stall_while_busy", stallBad, 0);
      checkOutput("wr_cycles", wrCnt, (!mis && !ld) ? 1 : 0);
      checkOutput("rd_cycles", rdCnt, (!mis && (ld || sz != 2'b10)) ? 1 : 0);
      if (!mis && !ld) begin
         checkOutput("wr_addr", wrAddr, {a[31:2], 2'b00});
         checkOutput("wr_data", wrData, newW);
      end
      req_valid = 1'b0;
   endtask

   // Checks every output is at its idle value.
   task automatic checkIdle(input string tag);
      @(negedge clk);
      checkOutput({tag, "_stall"}, {31'd0, stall}, 32'd0);
      checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      checkOutput({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
      checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      checkOutput({tag, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
      checkOutput({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
      checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkIdle("reset");

      // Word round trip
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h0);

      // Byte store via read-modify-write
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h11223344);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h22, 32'h000000AB);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h0);

      // Sub-word loads with sign and zero extension
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h30, 32'h80FF7F01);
      applyStimulus(1'b1, 2'b00, 1'b1, 32'h33, 32'h0);
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h33, 32'h0);
      applyStimulus(1'b1, 2'b01, 1'b1, 32'h30, 32'h0);
      applyStimulus(1'b1, 2'b01, 1'b1, 32'h32, 32'h0);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h32, 32'h0);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h32, 32'h1234BEEF);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h30, 32'h0);

      // Misaligned accesses
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h41, 32'h0);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h42, 32'h0);
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h40, 32'h0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h43, 32'h55555555);

      // Reset during the write half of a byte store
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h50, 32'hCAFEF00D);
      req_valid = 1'b1; req_load = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h51; req_wdata = 32'h00000077;
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("rmw_rd_cycle", {31'd0, mem_rd}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
      checkOutput("reset_mem_rd", {31'd0, mem_rd}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkIdle("post_reset");
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h50, 32'h0);
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h51, 32'h0);

      // Randomised mix over a small initialised window
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 2'b10, 1'b0, 32'h60 + 32'(i * 4), $urandom);
      end
      for (int i = 0; i < 24; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       32'h60 + 32'($urandom_range(0, 31)), $urandom);
      end

`ifdef LSU_PERF_CNT_EN
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      nLd = 0; nSt = 0; nMis = 0;
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h01020304);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h15, 32'h000000EE);
      applyStimulus(1'b1, 2'b00, 1'b1, 32'h15, 32'h0);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h16, 32'h0000A5A5);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h11, 32'h0);
      @(negedge clk);
      checkOutput("ld_cnt", {16'd0, ld_cnt}, 32'(nLd));
      checkOutput("st_cnt", {16'd0, st_cnt}, 32'(nSt));
      checkOutput("misalign_cnt", {24'd0, misalign_cnt}, 32'(nMis));
      checkOutput("ld_cnt_abs", {16'd0, ld_cnt}, 32'd2);
      checkOutput("st_cnt_abs", {16'd0, st_cnt}, 32'd3);
      checkOutput("misalign_cnt_abs", {24'd0, misalign_cnt}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("ld_cnt_reset", {16'd0, ld_cnt}, 32'd0);
      checkOutput("st_cnt_reset", {16'd0, st_cnt}, 32'd0);
      checkOutput("misalign_cnt_reset", {24'd0, misalign_cnt}, 32'd0);
`endif

      $display("[TB] accesses issued: %0d loads, %0d stores, %0d misaligned", nLd, nSt, nMis);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage of the 32-bit MIPS pipeline, directly upstream of the word-addressed data memory.
- Converts pipeline load/store requests (byte, halfword, word; signed or unsigned) into word-aligned data-memory accesses.
- Sub-word stores use read-modify-write. Misaligned accesses are flagged.
- Stalls the pipeline until each access completes.

Parameters:
- ADDR_W, 32, byte-address width of request and memory address buses.
- WORD_ADDR_BIT, 8, number of significant word-address bits. The memory holds 2^WORD_ADDR_BIT words; mem_addr[WORD_ADDR_BIT+1:2] selects the word.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  memory instruction present; held stable while stall=1.
- req_load  in  1  1=load, 0=store.
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  combinational; freezes the pipeline.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and misaligned accesses.
- misalign  out  1  valid with resp_valid; access rejected.
- mem_rd  out  1  data-memory read enable.
- mem_wr  out  1  data-memory write enable; memory commits on the negedge within this cycle.
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}); 0 when idle.
- mem_wdata  out  32  write word; 0 when mem_wr=0.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Reset:
  - Synchronous; forces state IDLE and discards the latched request.
  - resp_valid, misalign and resp_rdata are cleared to 0.
  - mem_rd and mem_wr are gated by ~reset, so no access occurs during a reset cycle, even mid-RMW.
- Request latch: on accept in IDLE, the unit registers addr, size, signed, load and wdata. Later changes on the req_* inputs are ignored.
- Byte lanes: little-endian. Lane n = bits [8n+7:8n], selected by addr[1:0]. A halfword uses addr[1] (lane pair 0-1 or 2-3).
- Misaligned cases: half with addr[0]=1, word with addr[1:0]!=0, and any size=11. These produce no memory access.
- IDLE:
  - stall = req_valid.
  - If req_valid, latch the request and go to:
    - RESP with misalign pending, if misaligned;
    - LD for a load;
    - ST for a word store;
    - RMW_RD for a byte/half store.
- LD: mem_rd=1. The extracted, extended lane data is registered into resp_rdata. Next state RESP.
- ST: mem_wr=1, mem_wdata=wdata. Next state RESP.
- RMW_RD: mem_rd=1. mem_rdata is registered into the merge buffer. Next state RMW_WR.
- RMW_WR:
  - mem_wr=1.
  - mem_wdata is the merge buffer with the target lane(s) replaced by wdata[7:0] or wdata[15:0]; all other lanes are unchanged.
  - Next state RESP.
- RESP:
  - resp_valid=1 and stall=0; the pipeline advances this cycle.
  - req_valid is ignored (same instruction still visible).
  - Next state IDLE.
- stall is 1 in IDLE with req_valid and in LD, ST, RMW_RD and RMW_WR; it is 0 in RESP.
- Latency, request cycle to resp_valid cycle:
  - load: 3 cycles;
  - word store: 3 cycles;
  - sub-word store: 4 cycles;
  - misaligned: 2 cycles.
- Back-to-back: a new request is accepted in the IDLE cycle immediately after RESP. Throughput is one access per 3 cycles minimum.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- Defined:
  - Adds outputs ld_cnt[15:0], st_cnt[15:0] and misalign_cnt[7:0].
  - Each counter increments by 1 in the RESP cycle of the matching access and wraps modulo its width.
  - A misaligned access increments only misalign_cnt.
  - Reset clears all counters to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Word round trip: word store of 0xDEADBEEF to 0x10, then an unsigned word load from 0x10 -> mem_wr for exactly one cycle with mem_addr=0x10; load resp_rdata=0xDEADBEEF on the 3rd cycle; stall=0 only in the RESP cycles.
- Byte store: memory word 0x11223344 at 0x20, then byte store of 0xAB to 0x22 -> sequence RMW_RD, RMW_WR; mem_wdata=0x11AB3344; resp_valid on the 4th cycle.
- Byte load: memory word 0x80FF7F01 at 0x30 ->
  - signed byte load from 0x33 gives 0xFFFFFF80;
  - unsigned byte load from 0x33 gives 0x00000080;
  - signed half load from 0x30 gives 0x00007F01;
  - signed half load from 0x32 gives 0xFFFF80FF.
- Misaligned accesses: half at 0x41, word at 0x42, size=11 at 0x40 -> each gives misalign=1 and resp_rdata=0 on the 2nd cycle, with mem_rd=mem_wr=0 throughout.
- Reset mid-RMW: assert reset during the RMW_WR cycle of a byte store -> mem_wr=0 that cycle and the memory word is unchanged. Next cycle: IDLE, all outputs 0, and a new request is accepted normally.
- With LSU_PERF_CNT_EN defined, issue 2 loads, 3 stores and 1 misaligned access -> ld_cnt=2, st_cnt=3, misalign_cnt=1. Then reset -> all counters 0.
